ascon_aead_seq: RTL and testbench
=================================

Name: ascon_aead_seq

Overview:
- Phase sequencer for ASCON-128 authenticated encryption around one shared round-iterated permutation core.
- Steps the core through four phases: initialization (p12), associated-data absorption (p6 per block), plaintext encryption (p6 per block) and finalization (p12).
- Drives state-source select, padding, key-XOR, domain-separation and output-valid strobes toward the state register and datapath.
- Sits between the PS-facing register interface (start, lengths) and the permutation/state datapath.

Parameters:
- LEN_W, 8: width of ad_len and pt_len in bytes.
- IDX_W, 6: block index width; must satisfy 2^IDX_W >= (2^LEN_W)/8 + 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin operation; sampled only in IDLE.
- ad_len  in  LEN_W  associated-data length in bytes.
- pt_len  in  LEN_W  plaintext length in bytes.
- perm_done  in  1  permutation core finished the requested rounds.
- perm_start  out  1  one-cycle pulse launching the core.
- perm_rounds  out  4  round count, 12 or 6; valid with perm_start.
- sel  out  3  state source select: 0 hold, 1 load IV||K||N, 2 absorb AD, 3 absorb PT, 4 key-XOR, 5 domain-sep.
- blk_idx  out  IDX_W  current AD/PT block index, from 0.
- blk_bytes  out  4  valid bytes in current block, 0..8.
- pad_en  out  1  current block is the last one (0x80 padding applies at byte blk_bytes).
- ct_valid  out  1  ciphertext block valid.
- tag_valid  out  1  tag valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any time, including mid-operation): FSM to IDLE; every output 0; counters 0. A perm_done arriving after reset is ignored.
- All outputs are decoded from registered state and counters; no combinational path from inputs to outputs.
- States and transitions:
  - IDLE: start=1 latches ad_len/pt_len, goes to LOAD.
  - LOAD: sel=1, one cycle, then INIT.
  - INIT: perm_start=1 and perm_rounds=12 in the entry cycle. Wait for perm_done; it is ignored in the entry cycle. Leave on the edge that samples perm_done=1, then INIT_K.
  - INIT_K: sel=4, one cycle. If ad_len!=0 go to AD_ABS, else SEP.
  - AD_ABS: sel=2, one cycle, then AD_PERM.
  - AD_PERM: same handshake as INIT with perm_rounds=6. On perm_done, blk_idx+1; if this was the last AD block go to SEP, else AD_ABS.
  - SEP: sel=5, one cycle; blk_idx cleared; then PT_ABS.
  - PT_ABS: sel=3, ct_valid=1, one cycle. If last PT block go to FIN_K, else PT_PERM.
  - PT_PERM: as AD_PERM with rounds=6, returning to PT_ABS.
  - FIN_K: sel=4, one cycle, then FINAL.
  - FINAL: p12 handshake, then TAG.
  - TAG: tag_valid=1, done=1, one cycle, then IDLE.
- Block arithmetic:
  - Block count = len[LEN_W-1:3] + 1, so there is always a final padded block, possibly carrying 0 data bytes.
  - Blocks before the last: blk_bytes=8, pad_en=0.
  - Last block: blk_bytes=len[2:0], pad_en=1.
  - ad_len=0: no AD blocks at all.
  - Lengths are 255 max, giving 32 blocks max; no overflow.
- start while busy is ignored, and latched lengths never change mid-operation.
- perm_done outside a PERM/INIT/FINAL wait state is ignored.
- perm_done held high across the entry cycle does not complete the phase early.
- Only the entry cycle generates perm_start; a multi-cycle perm_done never re-launches the core.

Decomposition:
- Shared package ascon_pkg holds:
  - the FSM state enum;
  - sel encodings;
  - constants ROUNDS_A=12 and ROUNDS_B=6;
  - the ASCON-128 IV constant 64'h80400c0600000000.
- One sub-module, ascon_blk_cnt: loads a length, produces blk_idx, blk_bytes and last, and advances on an increment strobe. It is instantiated once and reused for AD and PT.

Test Plan:
- Permutation stub asserts perm_done exactly perm_rounds cycles after perm_start. Cycle 0 is the cycle in which start=1 is sampled.
- ad_len=0, pt_len=0:
  - perm_start at cycles 2 (12) and 19 (12);
  - one ct_valid at cycle 17 with blk_bytes=0, pad_en=1;
  - tag_valid and done at cycle 32; busy low at 33.
- ad_len=8, pt_len=16:
  - AD_ABS at 16 (blk_bytes=8, pad_en=0) and 24 (blk_bytes=0, pad_en=1);
  - sel=5 at 32;
  - ct_valid at 33, 41, 49 with blk_bytes 8, 8, 0; pad_en only at 49;
  - done at 64.
- ad_len=3, pt_len=13:
  - single AD block with blk_bytes=3, pad_en=1;
  - PT blocks with blk_bytes 8 then 5; last has pad_en=1;
  - exactly four perm_start pulses, rounds 12, 6, 6, 12.
- ad_len=255, pt_len=255:
  - 32 AD absorbs and 32 ct_valid pulses;
  - last blocks have blk_bytes=7, blk_idx=31;
  - no index wrap.
- Raise rst during the second PT_PERM of the 8/16 case:
  - all outputs 0 immediately, without waiting for clk;
  - a stub perm_done afterwards causes no transition;
  - a new start runs a clean full sequence.
- start pulsed while busy, and perm_done forced high during AD_ABS or the INIT entry cycle:
  - no state change, no extra perm_start;
  - cycle counts identical to the unperturbed run.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared definitions for the ASCON-128 AEAD phase sequencer: FSM states,
// state-source select encodings and permutation round counts.
package ascon_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_INIT_K,
        S_AD_ABS,
        S_AD_PERM,
        S_SEP,
        S_PT_ABS,
        S_PT_PERM,
        S_FIN_K,
        S_FINAL,
        S_TAG
    } state_t;

    localparam logic [2:0] SEL_HOLD = 3'd0;
    localparam logic [2:0] SEL_LOAD = 3'd1;
    localparam logic [2:0] SEL_AD   = 3'd2;
    localparam logic [2:0] SEL_PT   = 3'd3;
    localparam logic [2:0] SEL_KEY  = 3'd4;
    localparam logic [2:0] SEL_SEP  = 3'd5;

    localparam logic [3:0] ROUNDS_A = 4'd12;
    localparam logic [3:0] ROUNDS_B = 4'd6;

    localparam logic [63:0] ASCON_IV = 64'h80400c0600000000;

    // States that launch the permutation core and wait for its completion.
    function automatic logic is_perm_state(state_t s);
        return (s == S_INIT) || (s == S_AD_PERM) || (s == S_PT_PERM) || (s == S_FINAL);
    endfunction

endpackage

// File: rtl/ascon_blk_cnt.sv
// Block counter for one AD or PT stream: tracks the block index and derives
// the valid-byte count and last-block flag from the loaded byte length.
module ascon_blk_cnt
    import ascon_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic [3:0]       bytes,
    output logic             last
);

    logic [LEN_W-1:0] len_q;
    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            idx_q <= '0;
        end else if (load) begin
            len_q <= len;
            idx_q <= '0;
        end else if (inc) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    // The final block always exists and carries len mod 8 bytes, possibly zero.
    always_comb begin
        idx   = idx_q;
        last  = (idx_q == IDX_W'(len_q[LEN_W-1:3]));
        bytes = last ? {1'b0, len_q[2:0]} : 4'd8;
    end

endmodule

// File: rtl/ascon_aead_seq.sv
// ASCON-128 AEAD phase sequencer: steps a shared permutation core through
// init, AD absorption, PT encryption and finalization.
module ascon_aead_seq
    import ascon_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] ad_len,
    input  logic [LEN_W-1:0] pt_len,
    input  logic             perm_done,
    output logic             perm_start,
    output logic [3:0]       perm_rounds,
    output logic [2:0]       sel,
    output logic [IDX_W-1:0] blk_idx,
    output logic [3:0]       blk_bytes,
    output logic             pad_en,
    output logic             ct_valid,
    output logic             tag_valid,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           next_state;
    logic             entry_q;
    logic             ad_nonzero_q;
    logic [LEN_W-1:0] pt_len_q;

    logic             cnt_load;
    logic [LEN_W-1:0] cnt_len;
    logic             cnt_inc;
    logic [IDX_W-1:0] cnt_idx;
    logic [3:0]       cnt_bytes;
    logic             cnt_last;
    logic             perm_ack;

    ascon_blk_cnt #(
        .LEN_W(LEN_W),
        .IDX_W(IDX_W)
    ) u_blk_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .len  (cnt_len),
        .inc  (cnt_inc),
        .idx  (cnt_idx),
        .bytes(cnt_bytes),
        .last (cnt_last)
    );

    // entry_q marks the first cycle of any state; perm states use it to launch
    // the core once and to ignore a perm_done already high on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            entry_q      <= 1'b0;
            ad_nonzero_q <= 1'b0;
            pt_len_q     <= '0;
        end else begin
            state   <= next_state;
            entry_q <= (next_state != state);
            if (state == S_IDLE && start) begin
                ad_nonzero_q <= (ad_len != '0);
                pt_len_q     <= pt_len;
            end
        end
    end

    assign perm_ack = perm_done && !entry_q;

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_len    = ad_len;
        cnt_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    cnt_load   = 1'b1;
                    next_state = S_LOAD;
                end
            end
            S_LOAD:   next_state = S_INIT;
            S_INIT:   if (perm_ack) next_state = S_INIT_K;
            S_INIT_K: next_state = ad_nonzero_q ? S_AD_ABS : S_SEP;
            S_AD_ABS: next_state = S_AD_PERM;
            S_AD_PERM: begin
                if (perm_ack) begin
                    cnt_inc    = 1'b1;
                    next_state = cnt_last ? S_SEP : S_AD_ABS;
                end
            end
            S_SEP: begin
                cnt_load   = 1'b1;
                cnt_len    = pt_len_q;
                next_state = S_PT_ABS;
            end
            S_PT_ABS: next_state = cnt_last ? S_FIN_K : S_PT_PERM;
            S_PT_PERM: begin
                if (perm_ack) begin
                    cnt_inc    = 1'b1;
                    next_state = S_PT_ABS;
                end
            end
            S_FIN_K:  next_state = S_FINAL;
            S_FINAL:  if (perm_ack) next_state = S_TAG;
            S_TAG:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Outputs depend only on registered state and counters.
    always_comb begin
        perm_start  = 1'b0;
        perm_rounds = 4'd0;
        sel         = SEL_HOLD;
        ct_valid    = 1'b0;
        tag_valid   = 1'b0;
        done        = 1'b0;
        busy        = (state != S_IDLE);
        blk_idx     = busy ? cnt_idx : '0;
        blk_bytes   = busy ? cnt_bytes : 4'd0;
        pad_en      = busy && cnt_last;
        if (is_perm_state(state) && entry_q) begin
            perm_start  = 1'b1;
            perm_rounds = (state == S_INIT || state == S_FINAL) ? ROUNDS_A : ROUNDS_B;
        end
        case (state)
            S_LOAD:   sel = SEL_LOAD;
            S_INIT_K: sel = SEL_KEY;
            S_AD_ABS: sel = SEL_AD;
            S_SEP:    sel = SEL_SEP;
            S_PT_ABS: begin
                sel      = SEL_PT;
                ct_valid = 1'b1;
            end
            S_FIN_K:  sel = SEL_KEY;
            S_TAG: begin
                tag_valid = 1'b1;
                done      = 1'b1;
            end
            default:  sel = SEL_HOLD;
        endcase
    end

endmodule

// File: tb/tb_ascon_aead_seq.sv
// Scoreboard bench for ascon_aead_seq: expected events are queued per run and
// a negedge monitor pops and compares each event the DUT presents.
module tb_ascon_aead_seq;

    localparam int EV_PS   = 0;
    localparam int EV_AD   = 1;
    localparam int EV_SEP  = 2;
    localparam int EV_CT   = 3;
    localparam int EV_DONE = 4;

    typedef struct {
        int kind;
        int cyc;
        int a;
        int b;
        int c;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] ad_len = 8'd0;
    logic [7:0] pt_len = 8'd0;
    logic       perm_done;
    logic       perm_start;
    logic [3:0] perm_rounds;
    logic [2:0] sel;
    logic [5:0] blk_idx;
    logic [3:0] blk_bytes;
    logic       pad_en;
    logic       ct_valid;
    logic       tag_valid;
    logic       busy;
    logic       done;

    logic stub_done = 1'b0;
    logic force_done = 1'b0;
    int   due = -1;
    int   cyc = 0;
    int   t0 = 0;
    int   cutoff = 1 << 30;
    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[$];

    assign perm_done = stub_done | force_done;

    ascon_aead_seq #(.LEN_W(8), .IDX_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ad_len     (ad_len),
        .pt_len     (pt_len),
        .perm_done  (perm_done),
        .perm_start (perm_start),
        .perm_rounds(perm_rounds),
        .sel        (sel),
        .blk_idx    (blk_idx),
        .blk_bytes  (blk_bytes),
        .pad_en     (pad_en),
        .ct_valid   (ct_valid),
        .tag_valid  (tag_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Permutation stub: completes exactly perm_rounds cycles after launch.
    always @(negedge clk) begin
        stub_done = (cyc == due);
        if (perm_start) due = cyc + int'(perm_rounds);
    end

    task automatic pushEv(input int kind, input int c, input int a, input int b, input int i);
        ev_t e;
        if (c < cutoff) begin
            e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.c = i;
            exp_q.push_back(e);
        end
    endtask

    task automatic checkOutput(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic observe(input int kind, input int c, input int a, input int b, input int i);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_event: got kind=%0d cyc=%0d a=%0d b=%0d idx=%0d want none",
                     kind, c, a, b, i);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != c || e.a != a || e.b != b || e.c != i) begin
                bad++;
                $display("[TB] FAIL event: got kind=%0d cyc=%0d a=%0d b=%0d idx=%0d want kind=%0d cyc=%0d a=%0d b=%0d idx=%0d",
                         kind, c, a, b, i, e.kind, e.cyc, e.a, e.b, e.c);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (perm_start) observe(EV_PS, cyc - t0, int'(perm_rounds), 0, 0);
            if (sel == 3'd2) observe(EV_AD, cyc - t0, int'(blk_bytes), int'(pad_en), int'(blk_idx));
            if (sel == 3'd5) observe(EV_SEP, cyc - t0, 0, 0, 0);
            if (ct_valid) observe(EV_CT, cyc - t0, int'(blk_bytes), int'(pad_en), int'(blk_idx));
            if (done) observe(EV_DONE, cyc - t0, int'(tag_valid), 0, 0);
        end
    end

    task automatic pushHand00();
        pushEv(EV_PS, 2, 12, 0, 0);
        pushEv(EV_SEP, 16, 0, 0, 0);
        pushEv(EV_CT, 17, 0, 1, 0);
        pushEv(EV_PS, 19, 12, 0, 0);
        pushEv(EV_DONE, 32, 1, 0, 0);
    endtask

    task automatic pushHand816();
        pushEv(EV_PS, 2, 12, 0, 0);
        pushEv(EV_AD, 16, 8, 0, 0);
        pushEv(EV_PS, 17, 6, 0, 0);
        pushEv(EV_AD, 24, 0, 1, 1);
        pushEv(EV_PS, 25, 6, 0, 0);
        pushEv(EV_SEP, 32, 0, 0, 0);
        pushEv(EV_CT, 33, 8, 0, 0);
        pushEv(EV_PS, 34, 6, 0, 0);
        pushEv(EV_CT, 41, 8, 0, 1);
        pushEv(EV_PS, 42, 6, 0, 0);
        pushEv(EV_CT, 49, 0, 1, 2);
        pushEv(EV_PS, 51, 12, 0, 0);
        pushEv(EV_DONE, 64, 1, 0, 0);
    endtask

    // Timing model: every absorb/perm pair is 8 cycles with a 6-round stub.
    task automatic pushModel(input int ad, input int pt);
        int nad, npt, sep, c, lastpt;
        nad = (ad == 0) ? 0 : (ad / 8) + 1;
        npt = (pt / 8) + 1;
        pushEv(EV_PS, 2, 12, 0, 0);
        for (int k = 0; k < nad; k++) begin
            pushEv(EV_AD, 16 + 8 * k, (k == nad - 1) ? ad % 8 : 8, (k == nad - 1) ? 1 : 0, k);
            pushEv(EV_PS, 17 + 8 * k, 6, 0, 0);
        end
        sep = 16 + 8 * nad;
        pushEv(EV_SEP, sep, 0, 0, 0);
        for (int j = 0; j < npt; j++) begin
            c = sep + 1 + 8 * j;
            pushEv(EV_CT, c, (j == npt - 1) ? pt % 8 : 8, (j == npt - 1) ? 1 : 0, j);
            if (j != npt - 1) pushEv(EV_PS, c + 1, 6, 0, 0);
        end
        lastpt = sep + 1 + 8 * (npt - 1);
        pushEv(EV_PS, lastpt + 2, 12, 0, 0);
        pushEv(EV_DONE, lastpt + 15, 1, 0, 0);
    endtask

    task automatic applyStimulus(input int ad, input int pt, input bit perturb, input int abort_at);
        int  rel;
        bit  finished = 0;
        bit  aborted = 0;
        @(negedge clk);
        ad_len = 8'(ad);
        pt_len = 8'(pt);
        start  = 1'b1;
        t0     = cyc;
        for (int i = 1; i < 800; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            start      = perturb && (rel == 5 || rel == 20 || rel == 40);
            force_done = perturb && (rel == 1 || rel == 2 || rel == 16);
            ad_len     = 8'(8'hA5 ^ i);
            pt_len     = 8'(8'h3C + i);
            if (abort_at != 0 && rel == abort_at) begin
                rst = 1'b1;
                #1;
                checkOutput("async_reset_outputs",
                            int'({perm_start, perm_rounds, sel, blk_idx, blk_bytes,
                                  pad_en, ct_valid, tag_valid, busy, done}), 0);
                aborted = 1;
                break;
            end
            if (done) begin
                finished = 1;
                break;
            end
        end
        start      = 1'b0;
        force_done = 1'b0;
        if (aborted) begin
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                checkOutput("idle_after_reset_busy", int'(busy), 0);
            end
        end else begin
            checkOutput("run_finished", int'(finished), 1);
            @(negedge clk);
            checkOutput("busy_low_after_done", int'(busy), 0);
        end
        checkOutput("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    int'({perm_start, perm_rounds, sel, blk_idx, blk_bytes,
                          pad_en, ct_valid, tag_valid, busy, done}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_outputs",
                    int'({perm_start, perm_rounds, sel, blk_idx, blk_bytes,
                          pad_en, ct_valid, tag_valid, busy, done}), 0);

        $display("[TB] run ad=0 pt=0");
        pushHand00();
        applyStimulus(0, 0, 0, 0);

        $display("[TB] run ad=8 pt=16");
        pushHand816();
        applyStimulus(8, 16, 0, 0);

        $display("[TB] run ad=3 pt=13");
        pushModel(3, 13);
        applyStimulus(3, 13, 0, 0);

        $display("[TB] run ad=255 pt=255");
        pushModel(255, 255);
        applyStimulus(255, 255, 0, 0);

        $display("[TB] run ad=8 pt=16 with start and perm_done disturbances");
        pushHand816();
        applyStimulus(8, 16, 1, 0);

        $display("[TB] run ad=8 pt=16 with reset in second PT_PERM");
        cutoff = 44;
        pushHand816();
        cutoff = 1 << 30;
        applyStimulus(8, 16, 0, 44);

        $display("[TB] clean run ad=8 pt=16 after reset");
        pushHand816();
        applyStimulus(8, 16, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
